// File: rtl/boot_loader.sv
// Boot loader: copies contiguous boot-ROM regions into NUM_TARGETS SRAM blocks,
// then verifies a trailing additive checksum byte before releasing N_BOOTED.
module boot_loader #(
  parameter int NUM_TARGETS = 3,
  parameter int ADDR_WIDTH  = 17,
  parameter int DATA_WIDTH  = 8,
  parameter int ROM_LATENCY = 2,
  parameter logic [NUM_TARGETS*ADDR_WIDTH-1:0] TARGET_LEN = {17'd2, 17'd0, 17'd4}
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   START,
  input  logic [DATA_WIDTH-1:0]  ROM_DATA,
  output logic [ADDR_WIDTH-1:0]  ROM_ADDR,
  output logic [ADDR_WIDTH-1:0]  ADDR,
  output logic [DATA_WIDTH-1:0]  DATA,
  output logic [NUM_TARGETS-1:0] N_WE,
  output logic                   N_BOOTED,
  output logic                   ERROR
);
  localparam int TW = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
  localparam int CW = $clog2(ROM_LATENCY + 1);
  localparam logic [CW-1:0] LAST = CW'(ROM_LATENCY - 1);

  function automatic int calc_total();
    int t = 0;
    for (int k = 0; k < NUM_TARGETS; k++) t += int'(TARGET_LEN[k*ADDR_WIDTH +: ADDR_WIDTH]);
    return t;
  endfunction

  function automatic logic [NUM_TARGETS*ADDR_WIDTH-1:0] calc_base();
    logic [NUM_TARGETS*ADDR_WIDTH-1:0] b = '0;
    logic [ADDR_WIDTH-1:0] acc = '0;
    for (int k = 0; k < NUM_TARGETS; k++) begin
      b[k*ADDR_WIDTH +: ADDR_WIDTH] = acc;
      acc = acc + TARGET_LEN[k*ADDR_WIDTH +: ADDR_WIDTH];
    end
    return b;
  endfunction

  // {found, index} of the lowest target >= from with a nonzero length
  function automatic logic [TW:0] find_nz(input logic [TW:0] from);
    logic [TW:0] r = '0;
    for (int k = NUM_TARGETS - 1; k >= 0; k--)
      if (k >= int'(from) && TARGET_LEN[k*ADDR_WIDTH +: ADDR_WIDTH] != '0) r = {1'b1, TW'(k)};
    return r;
  endfunction

  localparam int TOTAL = calc_total();
  localparam logic [ADDR_WIDTH-1:0] TOTAL_A = ADDR_WIDTH'(TOTAL);
  localparam logic [NUM_TARGETS*ADDR_WIDTH-1:0] BASE = calc_base();
  localparam logic [TW:0] FIRST = find_nz('0);

  if (ROM_LATENCY < 1) begin : g_bad_latency
    $error("boot_loader: ROM_LATENCY must be >= 1");
  end
  if (64'(TOTAL) + 64'd1 > (64'd1 << ADDR_WIDTH)) begin : g_bad_total
    $error("boot_loader: image plus checksum exceeds ROM address space");
  end

  typedef enum logic [2:0] {FETCH, WRITE, HOLD, CHECK, DONE, FAULT} state_t;

  state_t                state, state_d;
  logic [TW-1:0]         target, target_d;
  logic [ADDR_WIDTH-1:0] offset, offset_d;
  logic [CW-1:0]         cnt, cnt_d;
  logic [DATA_WIDTH-1:0] sum, sum_d, data_q, data_d;
  logic                  error_q, error_d;
  // Set by reset: the first FETCH edge only selects the first nonzero target
  logic                  arm, arm_d;
  logic [ADDR_WIDTH-1:0] cur_len, cur_base, offset_inc;
  logic [TW:0]           nxt;

  always_comb begin
    cur_len  = '0;
    cur_base = '0;
    for (int k = 0; k < NUM_TARGETS; k++)
      if (target == TW'(k)) begin
        cur_len  = TARGET_LEN[k*ADDR_WIDTH +: ADDR_WIDTH];
        cur_base = BASE[k*ADDR_WIDTH +: ADDR_WIDTH];
      end
  end

  assign offset_inc = offset + ADDR_WIDTH'(1);
  assign nxt        = find_nz((TW+1)'(target) + (TW+1)'(1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= FETCH;
      target  <= '0;
      offset  <= '0;
      cnt     <= '0;
      sum     <= '0;
      data_q  <= '0;
      error_q <= 1'b0;
      arm     <= 1'b1;
    end else begin
      state   <= state_d;
      target  <= target_d;
      offset  <= offset_d;
      cnt     <= cnt_d;
      sum     <= sum_d;
      data_q  <= data_d;
      error_q <= error_d;
      arm     <= arm_d;
    end
  end

  always_comb begin
    state_d  = state;
    target_d = target;
    offset_d = offset;
    cnt_d    = cnt;
    sum_d    = sum;
    data_d   = data_q;
    error_d  = error_q;
    arm_d    = arm;
    case (state)
      FETCH:
        if (arm) begin
          arm_d    = 1'b0;
          target_d = FIRST[TW-1:0];
          offset_d = '0;
          cnt_d    = '0;
          if (!FIRST[TW]) state_d = CHECK;
        end else if (cnt == LAST) begin
          cnt_d   = '0;
          data_d  = ROM_DATA;
          sum_d   = sum + ROM_DATA;
          state_d = WRITE;
        end else cnt_d = cnt + CW'(1);
      WRITE: state_d = HOLD;
      HOLD:
        if (offset_inc < cur_len) begin
          offset_d = offset_inc;
          state_d  = FETCH;
        end else if (nxt[TW]) begin
          target_d = nxt[TW-1:0];
          offset_d = '0;
          state_d  = FETCH;
        end else state_d = CHECK;
      CHECK:
        if (cnt == LAST) begin
          cnt_d   = '0;
          error_d = (ROM_DATA != sum);
          state_d = (ROM_DATA == sum) ? DONE : FAULT;
        end else cnt_d = cnt + CW'(1);
      DONE, FAULT:
        if (START) begin
          target_d = FIRST[TW-1:0];
          offset_d = '0;
          cnt_d    = '0;
          sum_d    = '0;
          state_d  = FIRST[TW] ? FETCH : CHECK;
        end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    ROM_ADDR = (state == CHECK || state == DONE || state == FAULT) ? TOTAL_A : cur_base + offset;
    for (int k = 0; k < NUM_TARGETS; k++)
      N_WE[k] = !(state == WRITE && target == TW'(k));
  end

  assign ADDR     = offset;
  assign DATA     = data_q;
  assign N_BOOTED = (state != DONE);
  assign ERROR    = error_q;
endmodule
